// File: rtl/shift_rows_stream.sv
// rtl/shift_rows_stream.sv - pipelined ShiftRows/InvShiftRows stream stage with 2-entry skid buffer
`timescale 1ns/1ps

module shift_rows_stream #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_data,
   input  logic              in_inv,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_inv
);

   localparam int W = 32 * NB;

   generate
      if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
         $error("shift_rows_stream: NB must be 4, 6 or 8");
      end
      if (TAG_W < 1) begin : g_bad_tag
         $error("shift_rows_stream: TAG_W must be at least 1");
      end
   endgenerate

   // Rijndael row offsets: wide (NB=8) blocks skip offset 2.
   function automatic int row_shift(input int r);
      if (NB == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   function automatic logic [W-1:0] permute(input logic [W-1:0] d, input logic inv);
      logic [W-1:0] o;
      int           r;
      int           c;
      int           src_f;
      int           src_i;
      o = '0;
      for (int k = 0; k < 4 * NB; k++) begin
         r     = k % 4;
         c     = k / 4;
         src_f = (c + row_shift(r)) % NB;
         src_i = (c - row_shift(r) + NB) % NB;
         o[8*k +: 8] = inv ? d[8*(4*src_i + r) +: 8] : d[8*(4*src_f + r) +: 8];
      end
      return o;
   endfunction

   logic              main_valid_q, main_valid_d;
   logic [W-1:0]      main_data_q,  main_data_d;
   logic [TAG_W-1:0]  main_tag_q,   main_tag_d;
   logic              main_inv_q,   main_inv_d;
   logic              skid_valid_q, skid_valid_d;
   logic [W-1:0]      skid_data_q,  skid_data_d;
   logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;
   logic              skid_inv_q,   skid_inv_d;
   logic              in_ready_q,   in_ready_d;

   logic              acc;
   logic              pop;
   logic [W-1:0]      new_data;

   assign new_data = permute(in_data, in_inv);

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_tag_d   = main_tag_q;
      main_inv_d   = main_inv_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_tag_d   = skid_tag_q;
      skid_inv_d   = skid_inv_q;
      acc          = in_valid && in_ready_q;
      pop          = main_valid_q && out_ready;

      if (!main_valid_q) begin
         if (acc) begin
            main_valid_d = 1'b1;
            main_data_d  = new_data;
            main_tag_d   = in_tag;
            main_inv_d   = in_inv;
         end
      end else if (pop) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            main_tag_d   = skid_tag_q;
            main_inv_d   = skid_inv_q;
            skid_valid_d = 1'b0;
         end else if (acc) begin
            main_data_d  = new_data;
            main_tag_d   = in_tag;
            main_inv_d   = in_inv;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (acc) begin
         skid_valid_d = 1'b1;
         skid_data_d  = new_data;
         skid_tag_d   = in_tag;
         skid_inv_d   = in_inv;
      end

      // Registered ready: no combinational path from out_ready to in_ready.
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_tag_q   <= '0;
         main_inv_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_tag_q   <= '0;
         skid_inv_q   <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_tag_q   <= main_tag_d;
         main_inv_q   <= main_inv_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_tag_q   <= skid_tag_d;
         skid_inv_q   <= skid_inv_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_tag   = main_tag_q;
   assign out_inv   = main_inv_q;

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb/tb_shift_rows_stream.sv - directed and randomized checks of shift_rows_stream for NB=4/6/8
`timescale 1ns/1ps

module tb_shift_rows_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [2:0]       iv, ii, ordy;
   logic [2:0][3:0]  itag;
   wire  [2:0]       ir, ov, oi;
   wire  [2:0][3:0]  otag;
   logic [127:0]     id4;
   logic [191:0]     id6;
   logic [255:0]     id8;
   wire  [127:0]     od4;
   wire  [191:0]     od6;
   wire  [255:0]     od8;

   int checks = 0;
   int errors = 0;

   shift_rows_stream #(.NB(4), .TAG_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id4),
      .in_inv(ii[0]), .in_tag(itag[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_data(od4), .out_tag(otag[0]), .out_inv(oi[0]));

   shift_rows_stream #(.NB(6), .TAG_W(4)) u6 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id6),
      .in_inv(ii[1]), .in_tag(itag[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_data(od6), .out_tag(otag[1]), .out_inv(oi[1]));

   shift_rows_stream #(.NB(8), .TAG_W(4)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id8),
      .in_inv(ii[2]), .in_tag(itag[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_data(od8), .out_tag(otag[2]), .out_inv(oi[2]));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: lay the block out as a 4 x nb byte matrix and rotate each row.
   function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] d, input logic inv);
      logic [7:0]   m[4][8];
      logic [7:0]   t;
      logic [255:0] o;
      int           s;
      o = '0;
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++) m[r][c] = d[8*(4*c + r) +: 8];
      for (int r = 0; r < 4; r++) begin
         s = (nb == 8 && r >= 2) ? r + 1 : r;
         for (int n = 0; n < s; n++) begin
            if (!inv) begin
               t = m[r][0];
               for (int c = 0; c < nb - 1; c++) m[r][c] = m[r][c+1];
               m[r][nb-1] = t;
            end else begin
               t = m[r][nb-1];
               for (int c = nb - 1; c > 0; c--) m[r][c] = m[r][c-1];
               m[r][0] = t;
            end
         end
      end
      for (int c = 0; c < nb; c++)
         for (int r = 0; r < 4; r++) o[8*(4*c + r) +: 8] = m[r][c];
      return o;
   endfunction

   function automatic logic [255:0] kseq(input int nb);
      logic [255:0] d;
      d = '0;
      for (int k = 0; k < 4 * nb; k++) d[8*k +: 8] = 8'(k);
      return d;
   endfunction

   function automatic logic [255:0] rnd(input int nb);
      logic [255:0] d;
      for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
      return d & ({256{1'b1}} >> (256 - 32 * nb));
   endfunction

   function automatic logic [255:0] get_od(input int i);
      case (i)
         0:       return {128'b0, od4};
         1:       return {64'b0, od6};
         default: return od8;
      endcase
   endfunction

   task automatic set_in(input int i, input logic [255:0] d);
      case (i)
         0:       id4 = d[127:0];
         1:       id6 = d[191:0];
         default: id8 = d;
      endcase
   endtask

   task automatic send(input int i, input logic [255:0] d, input logic inv, input logic [3:0] tag);
      chk("ready_before_send", 256'(ir[i]), 256'd1);
      set_in(i, d);
      ii[i]   = inv;
      itag[i] = tag;
      iv[i]   = 1'b1;
      @(posedge clk);
      #1;
      iv[i]   = 1'b0;
   endtask

   logic [255:0] o, d, f, snap;
   logic [3:0]   snap_tag;
   logic         snap_inv;
   logic [255:0] blk[6];
   logic         binv[6];
   logic [255:0] exp_d[$];
   logic [3:0]   exp_t[$];
   logic         exp_i[$];
   int           sent, got, cyc, dcyc[6];
   logic         acc_now, del_now;

   initial begin
      rst_n = 1'b0;
      iv = '0; ii = '0; ordy = '0; itag = '0;
      id4 = '0; id6 = '0; id8 = '0;
      #2;
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_ready", 256'(ir[i]), 256'd0);
         chk("rst_out_valid", 256'(ov[i]), 256'd0);
         chk("rst_out_data", get_od(i), 256'd0);
         chk("rst_out_tag", 256'(otag[i]), 256'd0);
         chk("rst_out_inv", 256'(oi[i]), 256'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      id4 = 'x; id6 = 'x; id8 = 'x;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk("ready_after_release", 256'(ir[i]), 256'd1);
         chk("idle_out_valid", 256'(ov[i]), 256'd0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) chk("idle_x_blocked", get_od(i), 256'd0);
      ordy = 3'b111;

      send(0, kseq(4), 1'b0, 4'd1);
      o = get_od(0);
      chk("fwd4_valid", 256'(ov[0]), 256'd1);
      chk("fwd4_b0", 256'(o[7:0]), 256'h00);
      chk("fwd4_b1", 256'(o[15:8]), 256'h05);
      chk("fwd4_b2", 256'(o[23:16]), 256'h0A);
      chk("fwd4_b3", 256'(o[31:24]), 256'h0F);
      chk("fwd4_b13", 256'(o[111:104]), 256'h01);
      chk("fwd4_tag", 256'(otag[0]), 256'd1);
      chk("fwd4_inv", 256'(oi[0]), 256'd0);
      chk("fwd4_full", o, ref_shift(4, kseq(4), 1'b0));

      send(0, kseq(4), 1'b1, 4'd2);
      o = get_od(0);
      chk("inv4_b1", 256'(o[15:8]), 256'h0D);
      chk("inv4_b5", 256'(o[47:40]), 256'h01);
      chk("inv4_b2", 256'(o[23:16]), 256'h0A);
      chk("inv4_b3", 256'(o[31:24]), 256'h07);
      chk("inv4_tag", 256'(otag[0]), 256'd2);
      chk("inv4_inv", 256'(oi[0]), 256'd1);

      send(2, kseq(8), 1'b0, 4'd3);
      o = get_od(2);
      chk("fwd8_b2", 256'(o[23:16]), 256'h0E);
      chk("fwd8_b3", 256'(o[31:24]), 256'h13);
      chk("fwd8_full", o, ref_shift(8, kseq(8), 1'b0));
      @(posedge clk); #1;

      // Forward then inverse back-to-back must restore the original block.
      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < 3; n++) begin
            d = rnd(4 + 2 * i);
            set_in(i, d);
            ii[i] = 1'b0; itag[i] = 4'(n); iv[i] = 1'b1;
            @(posedge clk); #1;
            f = get_od(i);
            chk("rt_fwd", f, ref_shift(4 + 2 * i, d, 1'b0));
            set_in(i, f);
            ii[i] = 1'b1; itag[i] = 4'(n + 8);
            @(posedge clk); #1;
            iv[i] = 1'b0;
            chk("rt_restore", get_od(i), d);
            chk("rt_inv_tag", 256'(otag[i]), 256'(n + 8));
         end
         @(posedge clk); #1;
         chk("rt_drained", 256'(ov[i]), 256'd0);
      end

      // Backpressure on the NB=6 instance.
      for (int j = 0; j < 6; j++) begin
         blk[j]  = rnd(6);
         binv[j] = 1'($urandom_range(0, 1));
      end
      ordy[1] = 1'b0;
      sent = 0; got = 0;
      set_in(1, blk[0]); ii[1] = binv[0]; itag[1] = 4'd0; iv[1] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         acc_now = iv[1] && ir[1];
         @(posedge clk);
         if (acc_now) begin
            exp_d.push_back(ref_shift(6, blk[sent], binv[sent]));
            exp_t.push_back(4'(sent));
            exp_i.push_back(binv[sent]);
            sent++;
         end
         #1;
         if (sent < 6) begin
            set_in(1, blk[sent]); ii[1] = binv[sent]; itag[1] = 4'(sent);
         end else iv[1] = 1'b0;
      end
      @(negedge clk);
      chk("bp_accepts", 256'(sent), 256'd2);
      chk("bp_ready_low", 256'(ir[1]), 256'd0);
      chk("bp_valid", 256'(ov[1]), 256'd1);
      snap = get_od(1); snap_tag = otag[1]; snap_inv = oi[1];
      chk("bp_head", snap, ref_shift(6, blk[0], binv[0]));
      repeat (3) @(negedge clk);
      chk("bp_hold_data", get_od(1), snap);
      chk("bp_hold_tag", 256'(otag[1]), 256'(snap_tag));
      chk("bp_hold_inv", 256'(oi[1]), 256'(snap_inv));

      ordy[1] = 1'b1;
      cyc = 0;
      while (got < 6 && cyc < 30) begin
         del_now = ov[1] && ordy[1];
         if (del_now && exp_d.size() > 0) begin
            chk("bp_order_tag", 256'(otag[1]), 256'(exp_t.pop_front()));
            chk("bp_order_data", get_od(1), exp_d.pop_front());
            chk("bp_order_inv", 256'(oi[1]), 256'(exp_i.pop_front()));
            dcyc[got] = cyc;
            got++;
         end
         acc_now = iv[1] && ir[1];
         @(posedge clk);
         if (acc_now) begin
            exp_d.push_back(ref_shift(6, blk[sent], binv[sent]));
            exp_t.push_back(4'(sent));
            exp_i.push_back(binv[sent]);
            sent++;
         end
         #1;
         if (sent < 6) begin
            set_in(1, blk[sent]); ii[1] = binv[sent]; itag[1] = 4'(sent);
         end else iv[1] = 1'b0;
         @(negedge clk);
         cyc++;
      end
      chk("bp_delivered", 256'(got), 256'd6);
      chk("bp_sent", 256'(sent), 256'd6);
      if (got == 6) chk("bp_throughput", 256'(dcyc[5] - dcyc[0]), 256'd5);
      chk("bp_no_extra", 256'(ov[1]), 256'd0);

      // Mid-stream reset with both entries of the NB=4 instance occupied.
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      send(0, rnd(4), 1'b0, 4'd7);
      send(0, rnd(4), 1'b1, 4'd8);
      chk("mr_full_ready", 256'(ir[0]), 256'd0);
      chk("mr_full_valid", 256'(ov[0]), 256'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_async_ready", 256'(ir[0]), 256'd0);
      chk("mr_async_valid", 256'(ov[0]), 256'd0);
      chk("mr_async_data", get_od(0), 256'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("mr_ready_back", 256'(ir[0]), 256'd1);
      for (int c = 0; c < 3; c++) begin
         chk("mr_no_stale", 256'(ov[0]), 256'd0);
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_rows_stream.md
Name: shift_rows_stream

Overview:
- Parametrised, pipelined ShiftRows / InvShiftRows engine for the AES/Rijndael datapath.
- Supports Rijndael block widths of 4, 6 or 8 columns.
- Direction is selected per transaction, so encrypt and decrypt rounds share one instance.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey.
- Uses a valid/ready stream interface with a 2-entry skid buffer, so in_ready is driven from a register.

Parameters:
- NB, 4, number of state columns; legal values are 4, 6 and 8. Any other value must cause an elaboration error.
- TAG_W, 4, width of the sideband tag carried alongside each block. Must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input block valid
- in_ready  output  1  block accepted when in_valid && in_ready
- in_data  input  32*NB  state bytes
- in_inv  input  1  0 = forward ShiftRows, 1 = InvShiftRows
- in_tag  input  TAG_W  opaque sideband, passed through unchanged
- out_valid  output  1  output block valid
- out_ready  input  1  downstream accept
- out_data  output  32*NB  shifted state
- out_tag  output  TAG_W  tag of the block on out_data
- out_inv  output  1  direction used for the block on out_data

Behaviour:
- Byte k occupies bits [8k+7:8k]. Its row is r = k mod 4 and its column is c = k div 4 (column-major).
- Row shift s_r:
  - NB=4 and NB=6: s = {0,1,2,3}.
  - NB=8: s = {0,1,3,4}.
- Forward (in_inv=0): out(r,c) = in(r,(c+s_r) mod NB).
- Inverse (in_inv=1): out(r,c) = in(r,(c-s_r+NB) mod NB).
- Permutation is applied combinationally on the input side. Only permuted data is stored.
- Storage:
  - Main register (main_valid/data/tag/inv) drives the out_* ports directly.
  - Skid register (skid_valid/...) holds one overflow block.
- in_ready = !skid_valid. This is a pure register output with no combinational path from out_ready.
- out_valid = main_valid. Latency is 1 cycle from accept to out_valid. Throughput is 1 block/cycle while out_ready=1.
- Per-cycle update, with acc = in_valid && in_ready and pop = main_valid && out_ready:
  - main empty, acc: main <= new.
  - main full, pop, skid empty, acc: main <= new.
  - main full, pop, skid full: main <= skid, skid_valid <= 0. in_ready=0, so no acc is possible.
  - main full, no pop, acc: skid <= new. in_ready falls next cycle.
  - main full, no pop, no acc: hold.
  - pop with no acc and skid empty: main_valid <= 0.
- Ordering: blocks leave in strict acceptance order. Tag and inv always travel with their own data.
- While out_valid=1 && out_ready=0, out_data, out_tag and out_inv must hold stable.
- Reset (asynchronous, any time including mid-transfer):
  - main_valid=0, skid_valid=0, out_valid=0.
  - in_ready=0 during reset, then 1 from the first clock edge after release.
  - out_data, out_tag and out_inv reset to 0.
  - In-flight blocks are discarded.
- Data registers update only on load, never on idle cycles (power).
- in_data must be ignored when in_valid=0. X on idle inputs must not propagate to out_* while out_valid=0.

Test Plan:
- NB=4, forward, in byte k = k (0x00..0x0F) -> one cycle later:
  - out byte0=0x00, byte1=0x05, byte2=0x0A, byte3=0x0F, byte13=0x01.
- NB=4, inverse, same input -> out byte1=0x0D, byte5=0x01, byte2=0x0A, byte3=0x07.
- Round trip: forward then inverse, back-to-back, with random data for NB=4, 6 and 8 -> original block restored.
- NB=8, forward, in byte k = k -> out byte2=0x0E (row 2 shift 3), out byte3=0x13 (row 3 shift 4).
- Backpressure:
  - Stream 6 tagged blocks with out_ready=0 -> in_ready deasserts after 2 accepts.
  - Outputs hold stable while stalled.
  - Releasing out_ready delivers tags 0..5 in order with no loss or duplication, and sustains 1 block/cycle.
- Mid-stream reset:
  - Assert rst_n=0 with both entries full -> out_valid=0 and in_ready=0 immediately, without waiting for a clock edge.
  - After release, in_ready=1 on the first clock edge and no stale block is emitted.
